// File: rtl/lobster_assoc_cache.sv
// N-way set-associative, one-word-per-line cache with round-robin replacement,
// single outstanding miss refill, per-line invalidate, flush walk and hit/miss counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | accepting requests; hits and writes answered next cycle
// MISS_REQ  | read miss pending, refill request held until mem_req_ready
// MISS_WAIT | refill request accepted, waiting for mem_rsp_valid
// FLUSH     | clearing one set per cycle, requests blocked
module lobster_assoc_cache #(
  parameter int ADDR_WIDTH = 36,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_SETS   = 256,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  inv_valid,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, FLUSH} state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]      tag_mem   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_mem  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_mem [NUM_SETS];
  logic [WAY_W-1:0]      vptr      [NUM_SETS];

  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  kill;
  logic [IDX_W-1:0]      flush_idx;

  // In IDLE the lookup port serves the incoming request; during a miss it serves the pending line.
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic [IDX_W-1:0]      lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [IDX_W-1:0]      inv_idx;
  logic [TAG_W-1:0]      inv_tag;
  logic                  accept, fill, inv_lk;
  logic                  hit, vic_found;
  logic [WAY_W-1:0]      hit_way, vic_way;
  logic                  ins_en, ins_valid, ins_adv;
  logic [WAY_W-1:0]      ins_way;
  logic [DATA_WIDTH-1:0] ins_data;

  assign lk_addr       = (state == IDLE) ? req_addr : pend_addr;
  assign lk_idx        = lk_addr[IDX_W-1:0];
  assign lk_tag        = lk_addr[ADDR_WIDTH-1:IDX_W];
  assign inv_idx       = inv_addr[IDX_W-1:0];
  assign inv_tag       = inv_addr[ADDR_WIDTH-1:IDX_W];
  assign req_ready     = (state == IDLE) && !rst;
  assign accept        = req_valid && req_ready;
  assign fill          = (state == MISS_WAIT) && mem_rsp_valid;
  assign inv_lk        = inv_valid && (inv_addr == lk_addr);
  assign mem_req_valid = (state == MISS_REQ) && !rst;
  assign mem_req_addr  = mem_req_valid ? pend_addr : '0;

  // Tag compare and victim choice: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_way   = vptr[lk_idx];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_mem[lk_idx][w] && (tag_mem[lk_idx][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!vic_found && !valid_mem[lk_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
  end

  // Line install from a write or a refill; a same-cycle invalidate (or earlier kill) leaves it invalid.
  always_comb begin
    ins_en    = 1'b0;
    ins_way   = vic_way;
    ins_data  = req_wdata;
    ins_valid = 1'b1;
    ins_adv   = 1'b0;
    if (accept && req_we) begin
      ins_en    = 1'b1;
      ins_way   = hit ? hit_way : vic_way;
      ins_valid = !inv_lk;
      ins_adv   = !hit && !vic_found;
    end else if (fill) begin
      ins_en    = 1'b1;
      ins_data  = mem_rsp_data;
      ins_valid = !(kill || inv_lk);
      ins_adv   = !vic_found;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !req_we && !hit)  state_nxt = MISS_REQ;
        else if (!req_valid && flush)   state_nxt = FLUSH;
      end
      MISS_REQ:  if (mem_req_ready) state_nxt = MISS_WAIT;
      MISS_WAIT: if (mem_rsp_valid) state_nxt = IDLE;
      FLUSH:     if (flush_idx == IDX_W'(NUM_SETS - 1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Responses, miss bookkeeping, flush walk index and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_rdata  <= '0;
      flush_done <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      pend_addr  <= '0;
      kill       <= 1'b0;
      flush_idx  <= '0;
    end else begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_rdata  <= '0;
      flush_done <= 1'b0;
      if (accept) begin
        if (req_we || hit) begin
          rsp_valid <= 1'b1;
          rsp_hit   <= hit;
          rsp_rdata <= req_we ? '0 : data_mem[lk_idx][hit_way];
        end else begin
          pend_addr <= req_addr;
          kill      <= 1'b0;
        end
        if (hit) begin
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end else begin
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
      end
      if ((state == MISS_REQ || state == MISS_WAIT) && inv_lk) kill <= 1'b1;
      if (fill) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem_rsp_data;
        kill      <= 1'b0;
      end
      if (state == FLUSH) begin
        flush_idx <= flush_idx + 1'b1;
        if (flush_idx == IDX_W'(NUM_SETS - 1)) flush_done <= 1'b1;
      end else begin
        flush_idx <= '0;
      end
    end
  end

  // Valid bits and victim pointers: flush, then invalidate, then install (later writes win).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        vptr[s]      <= '0;
      end
    end else begin
      if (state == FLUSH) begin
        valid_mem[flush_idx] <= '0;
        vptr[flush_idx]      <= '0;
      end
      if (inv_valid) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (tag_mem[inv_idx][w] == inv_tag) valid_mem[inv_idx][w] <= 1'b0;
        end
      end
      if (ins_en) begin
        valid_mem[lk_idx][ins_way] <= ins_valid;
        if (ins_adv) begin
          vptr[lk_idx] <= (vptr[lk_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : vptr[lk_idx] + 1'b1;
        end
      end
    end
  end

  // Tag and data storage; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (ins_en) begin
      tag_mem[lk_idx][ins_way]  <= lk_tag;
      data_mem[lk_idx][ins_way] <= ins_data;
    end
  end

endmodule

// File: doc/lobster_assoc_cache.md
Name: lobster_assoc_cache

Overview:
- Parametrised N-way set-associative cache and successor to the single-way hashed cache.
- Supports valid/ready request handshake, tag compare, miss refill from a backing memory port, per-line invalidate, whole-cache flush walk and hit/miss statistics counters.
- Sits between a core load/store port and the memory/bus interface. One word per line.

Parameters:
- ADDR_WIDTH, 36, word address width.
- DATA_WIDTH, 64, line/word width.
- NUM_SETS, 256, number of sets; power of two, >=2. IDX_W = log2(NUM_SETS).
- NUM_WAYS, 2, ways per set; power of two, 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_hit  out  1  request hit in cache
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- inv_valid  in  1  invalidate line holding inv_addr
- inv_addr  in  ADDR_WIDTH  invalidate address
- flush  in  1  start full invalidate walk; sampled only in IDLE
- flush_done  out  1  one-cycle pulse when walk completes
- mem_req_valid  out  1  refill request
- mem_req_ready  in  1  memory accepts refill request
- mem_req_addr  out  ADDR_WIDTH  refill address (= missing req_addr)
- mem_rsp_valid  in  1  refill data present
- mem_rsp_data  in  DATA_WIDTH  refill data
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating miss counter

Behaviour:
- Address split: index = addr[IDX_W-1:0], tag = addr[ADDR_WIDTH-1:IDX_W]. Per line: tag, data, valid. Per set: round-robin victim pointer.
- Reset (sync): all valid bits 0, victim pointers 0, counters 0, state IDLE, kill flag 0.
- Reset outputs: req_ready=0 during the reset cycle, then 1. rsp_valid, rsp_hit, rsp_rdata, mem_req_valid, mem_req_addr, flush_done all 0.
- States: IDLE, MISS_REQ, MISS_WAIT, FLUSH.
- IDLE: req_ready=1. Tag compare is combinational at acceptance (cycle T); results are registered.
- Read hit: rsp_valid=1, rsp_hit=1, rsp_rdata=line data at T+1. Stay IDLE, so back-to-back requests run at 1/cycle. hit_count++.
- Read miss: at T+1 state MISS_REQ, req_ready=0, mem_req_valid=1, mem_req_addr=req_addr, miss_count++. Hold mem_req_valid and mem_req_addr stable until mem_req_ready.
  - Handshake cycle -> MISS_WAIT. mem_rsp_valid before the handshake is ignored.
  - In MISS_WAIT, the cycle mem_rsp_valid=1 fills the victim way (tag, data, valid=1). The next cycle gives rsp_valid=1, rsp_hit=0, rsp_rdata=mem_rsp_data, and the state returns to IDLE.
- Write: accepted in IDLE only. No memory traffic.
  - Write hit: update data at T+1, rsp_valid=1, rsp_hit=1, hit_count++.
  - Write miss: install in victim way at T+1, rsp_valid=1, rsp_hit=0, miss_count++.
  - A request accepted at T+1 observes the written value.
- Victim selection: lowest-numbered invalid way if any. Otherwise way = set victim pointer, and the pointer increments mod NUM_WAYS after each replacement of a valid line.
- Invalidate: accepted every cycle in any state. At the clock edge it clears valid on any way in set inv_addr whose tag matches.
  - Same cycle as an accepted write to the same line: invalidate wins, line ends invalid; the response still reports the write's hit status.
  - Matches the pending miss line in MISS_REQ/MISS_WAIT: set the kill flag. The fill then leaves the line invalid, the response is still returned with memory data, and the kill flag clears.
- Flush: flush=1 in IDLE with req_valid=0 -> FLUSH; if req_valid=1 in the same cycle, the request takes priority and flush is ignored.
  - FLUSH clears one set per cycle for sets 0..NUM_SETS-1 and resets victim pointers; req_ready=0 throughout.
  - flush_done=1 on the cycle after the last set is cleared; state returns to IDLE. Walk takes NUM_SETS cycles.
- Counters saturate at 0xFFFFFFFF and do not wrap.
- Reset mid-miss or mid-flush: sync reset aborts to IDLE with all lines invalid. A late mem_rsp_valid is ignored.
- Only one outstanding miss; no hit-under-miss.

Test Plan:
- Reset, then read 0x000000100 -> miss. mem_req_addr=0x000000100; respond 0xDEADBEEF -> rsp_hit=0, rdata=0xDEADBEEF. Re-read -> rsp_hit=1 at T+1, same data; hit_count=1, miss_count=1.
- Write 0x12345678 to 0x000000100, then 0x55 to 0x000001100 (same set 0x00, 2 ways), then read both -> both hit. Write 0x000002100 -> evicts way 0 (pointer 0). Read 0x000000100 -> miss.
- Read miss to 0x000003200 with mem_req_ready low 5 cycles -> mem_req_valid and mem_req_addr stable. inv_valid for 0x000003200 during MISS_WAIT -> response data returned; next read of it misses.
- Fill 4 lines, pulse flush -> req_ready=0 for 256 cycles, flush_done pulses once, all 4 re-reads miss.
- Write plus inv_valid on the same address in the same cycle -> next read misses.
- Assert rst during MISS_WAIT, then drive mem_rsp_valid -> no rsp_valid, counters 0, req_ready=1 after reset.
